// File: rtl/mc_cmd_pkg.sv
// Shared definitions for the issue FIFO and its dispatcher: DRAM command
// encodings ({cs_n, ras_n, cas_n, we_n}) and the FIFO entry layout.
package mc_cmd_pkg;

  localparam int ISU_FIFO_WIDTH = 21;

  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [13:0] addr;
    logic [2:0]  bank;
  } issue_fifo_cmd_in_t;

  // Anything outside the five real commands (including NOP) never reaches the pins.
  function automatic logic is_real_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ACT) || (cmd == CMD_RD) || (cmd == CMD_WR) ||
           (cmd == CMD_PRE) || (cmd == CMD_REF);
  endfunction

endpackage

// File: rtl/issue_cmd_dispatcher_if.sv
// FIFO-read and DRAM-pin bundle of the issue command dispatcher.
interface issue_cmd_dispatcher_if;
  import mc_cmd_pkg::*;

  logic                      dispatch_en;
  logic [ISU_FIFO_WIDTH-1:0] fifo_data;
  logic                      fifo_empty;
  logic                      fifo_ren;
  logic                      dram_cs_n;
  logic                      dram_ras_n;
  logic                      dram_cas_n;
  logic                      dram_we_n;
  logic [13:0]               dram_addr;
  logic [2:0]                dram_ba;
  logic                      cmd_issued;
  logic                      timer_busy;

  modport master (
    input  dispatch_en, fifo_data, fifo_empty,
    output fifo_ren, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
           dram_addr, dram_ba, cmd_issued, timer_busy
  );

  modport slave (
    output dispatch_en, fifo_data, fifo_empty,
    input  fifo_ren, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
           dram_addr, dram_ba, cmd_issued, timer_busy
  );

endinterface

// File: rtl/bank_timer.sv
// Per-bank tRCD/tRP/tRAS saturating down-counters with ready flags.
module bank_timer #(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RAS = 8,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_act,
  input  logic load_pre,
  output logic act_ready,
  output logic rdwr_ready,
  output logic pre_ready,
  output logic busy_d
);

  localparam logic [CNT_W-1:0] RCD_INIT = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_INIT  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RAS_INIT = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] trcd_q, trcd_d;
  logic [CNT_W-1:0] trp_q, trp_d;
  logic [CNT_W-1:0] tras_q, tras_d;

  // Loading T-1 makes the dependent command reach the pins exactly T cycles later.
  always_comb begin
    trcd_d = (trcd_q != '0) ? trcd_q - ONE : '0;
    trp_d  = (trp_q  != '0) ? trp_q  - ONE : '0;
    tras_d = (tras_q != '0) ? tras_q - ONE : '0;
    if (load_act) begin
      trcd_d = RCD_INIT;
      tras_d = RAS_INIT;
    end
    if (load_pre) begin
      trp_d = RP_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trcd_q <= '0;
      trp_q  <= '0;
      tras_q <= '0;
    end else begin
      trcd_q <= trcd_d;
      trp_q  <= trp_d;
      tras_q <= tras_d;
    end
  end

  assign act_ready  = (trp_q == '0);
  assign rdwr_ready = (trcd_q == '0);
  assign pre_ready  = (tras_q == '0);
  assign busy_d     = (trcd_d != '0) || (trp_d != '0) || (tras_d != '0);

endmodule

// File: rtl/issue_cmd_dispatcher.sv
// In-order reader of the issue FIFO: checks DRAM timing for the head entry,
// pops it when legal and drives the registered DRAM command/address pins.
module issue_cmd_dispatcher
  import mc_cmd_pkg::*;
#(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RAS = 8,
  parameter int T_CCD = 2,
  parameter int T_RFC = 20,
  parameter int CNT_W = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  issue_cmd_dispatcher_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam logic [CNT_W-1:0] CCD_INIT = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] RFC_INIT = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  issue_fifo_cmd_in_t head;
  logic               legal;
  logic               fifo_ren;
  logic [1:0]         state;
  logic [7:0]         load_act, load_pre;
  logic [7:0]         act_ready, rdwr_ready, pre_ready, bank_busy_d;

  logic [CNT_W-1:0] tccd_q, tccd_d;
  logic [CNT_W-1:0] trfc_q, trfc_d;
  logic [3:0]       cmd_pins_q, cmd_pins_d;
  logic [13:0]      addr_q, addr_d;
  logic [2:0]       ba_q, ba_d;
  logic             cmd_issued_q, cmd_issued_d;
  logic             timer_busy_q, timer_busy_d;

  assign head = bus.fifo_data;

  for (genvar g = 0; g < 8; g++) begin : g_bank
    bank_timer #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_RAS (T_RAS),
      .CNT_W (CNT_W)
    ) u_bank_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_act   (load_act[g]),
      .load_pre   (load_pre[g]),
      .act_ready  (act_ready[g]),
      .rdwr_ready (rdwr_ready[g]),
      .pre_ready  (pre_ready[g]),
      .busy_d     (bank_busy_d[g])
    );
  end

  always_comb begin
    legal = 1'b1;
    case (head.cmd)
      CMD_ACT:         legal = act_ready[head.bank] && (trfc_q == '0);
      CMD_RD, CMD_WR:  legal = rdwr_ready[head.bank] && (tccd_q == '0) && (trfc_q == '0);
      CMD_PRE:         legal = pre_ready[head.bank] && (trfc_q == '0);
      CMD_REF:         legal = (&act_ready) && (trfc_q == '0);
      default:         legal = 1'b1;
    endcase
  end

  assign fifo_ren = rst_n && bus.dispatch_en && !bus.fifo_empty && legal;

  always_comb begin
    state = ST_IDLE;
    if (fifo_ren) begin
      state = ST_ISSUE;
    end else if (bus.dispatch_en && !bus.fifo_empty) begin
      state = ST_WAIT;
    end
  end

  always_comb begin
    load_act = '0;
    load_pre = '0;
    if (fifo_ren && head.cmd == CMD_ACT) load_act = 8'd1 << head.bank;
    if (fifo_ren && head.cmd == CMD_PRE) load_pre = 8'd1 << head.bank;

    tccd_d = (tccd_q != '0) ? tccd_q - ONE : '0;
    trfc_d = (trfc_q != '0) ? trfc_q - ONE : '0;
    if (fifo_ren && (head.cmd == CMD_RD || head.cmd == CMD_WR)) tccd_d = CCD_INIT;
    if (fifo_ren && head.cmd == CMD_REF) trfc_d = RFC_INIT;

    timer_busy_d = (|bank_busy_d) || (tccd_d != '0) || (trfc_d != '0);
  end

  // Address/bank follow every pop; the command only for real commands.
  always_comb begin
    cmd_pins_d   = CMD_NOP;
    addr_d       = addr_q;
    ba_d         = ba_q;
    cmd_issued_d = 1'b0;
    if (fifo_ren) begin
      addr_d = head.addr;
      ba_d   = head.bank;
      if (is_real_cmd(head.cmd)) begin
        cmd_pins_d   = head.cmd;
        cmd_issued_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tccd_q       <= '0;
      trfc_q       <= '0;
      cmd_pins_q   <= CMD_NOP;
      addr_q       <= '0;
      ba_q         <= '0;
      cmd_issued_q <= 1'b0;
      timer_busy_q <= 1'b0;
    end else begin
      tccd_q       <= tccd_d;
      trfc_q       <= trfc_d;
      cmd_pins_q   <= cmd_pins_d;
      addr_q       <= addr_d;
      ba_q         <= ba_d;
      cmd_issued_q <= cmd_issued_d;
      timer_busy_q <= timer_busy_d;
    end
  end

  assign bus.fifo_ren   = fifo_ren;
  assign bus.dram_cs_n  = cmd_pins_q[3];
  assign bus.dram_ras_n = cmd_pins_q[2];
  assign bus.dram_cas_n = cmd_pins_q[1];
  assign bus.dram_we_n  = cmd_pins_q[0];
  assign bus.dram_addr  = addr_q;
  assign bus.dram_ba    = ba_q;
  assign bus.cmd_issued = cmd_issued_q;
  assign bus.timer_busy = timer_busy_q;

  a_issue_only_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_ISSUE) |-> (legal && !bus.fifo_empty && bus.dispatch_en));

endmodule

// File: tb/tb_issue_cmd_dispatcher.sv
// Scoreboard bench for issue_cmd_dispatcher: a FIFO model feeds directed entries,
// expected pin commands and arrival cycles are queued and checked by a monitor.
module tb_issue_cmd_dispatcher;
  import mc_cmd_pkg::*;

  typedef struct {
    logic [3:0]  cmd;
    logic [13:0] addr;
    logic [2:0]  bank;
    int          when;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   base = 0;
  bit   mon_en = 1'b0;

  logic [ISU_FIFO_WIDTH-1:0] fifo_mem[$];
  exp_t                      exp_q[$];

  issue_cmd_dispatcher_if bus();

  issue_cmd_dispatcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fifoUpdate();
    bus.fifo_empty = (fifo_mem.size() == 0);
    bus.fifo_data  = (fifo_mem.size() != 0) ? fifo_mem[0] : '0;
  endtask

  task automatic expectIssue(input logic [3:0] cmd, input logic [13:0] addr, input logic [2:0] bank,
                             input int offset);
    exp_t e;
    e.cmd  = cmd;
    e.addr = addr;
    e.bank = bank;
    e.when = base + offset;
    exp_q.push_back(e);
  endtask

  // Push an entry into the FIFO model; offset is the expected pin cycle relative to base.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [13:0] addr, input logic [2:0] bank,
                               input bit expect_issue, input int offset);
    fifo_mem.push_back({cmd, addr, bank});
    fifoUpdate();
    if (expect_issue) expectIssue(cmd, addr, bank, offset);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((bus.timer_busy !== 1'b0 || fifo_mem.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL idle_timeout actual=busy required=idle within %0d cycles", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (bus.fifo_ren === 1'b1) begin
      #1;
      if (fifo_mem.size() != 0) void'(fifo_mem.pop_front());
      fifoUpdate();
    end
  end

  // Monitor: every issued command must match the scoreboard head, otherwise pins stay NOP.
  always @(negedge clk) begin : monitor
    logic [3:0] pins;
    exp_t       e;
    if (mon_en) begin
      pins = {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
      if (bus.cmd_issued === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_issue actual=%0h required=none (cycle %0d)", pins, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("issue_cmd", 32'(pins), 32'(e.cmd));
          checkOutput("issue_addr", 32'(bus.dram_addr), 32'(e.addr));
          checkOutput("issue_ba", 32'(bus.dram_ba), 32'(e.bank));
          checkOutput("issue_cycle", 32'(cyc), 32'(e.when));
          checkOutput("busy_after_issue", 32'(bus.timer_busy), 32'd1);
        end
      end else begin
        checkOutput("idle_pins_nop", 32'(pins), 32'(CMD_NOP));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.dispatch_en = 1'b1;
    fifoUpdate();

    // Reset held for 3 cycles with ACT at the head
    applyStimulus(CMD_ACT, 14'h0100, 3'd2, 1'b0, 0);
    applyStimulus(CMD_RD,  14'h0010, 3'd2, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mon_en = 1'b1;
      checkOutput("rst_fifo_ren", 32'(bus.fifo_ren), 32'd0);
      checkOutput("rst_cmd_issued", 32'(bus.cmd_issued), 32'd0);
      checkOutput("rst_addr", 32'(bus.dram_addr), 32'd0);
      checkOutput("rst_ba", 32'(bus.dram_ba), 32'd0);
      checkOutput("rst_timer_busy", 32'(bus.timer_busy), 32'd0);
    end
    checkOutput("rst_head_kept", 32'(fifo_mem.size()), 32'd2);
    rst_n = 1'b1;
    base = cyc;
    expectIssue(CMD_ACT, 14'h0100, 3'd2, 1);
    expectIssue(CMD_RD,  14'h0010, 3'd2, 4);
    waitIdle(40);

    // RD to a bank with no pending tRCD goes out immediately
    base = cyc;
    applyStimulus(CMD_RD, 14'h0020, 3'd5, 1'b1, 1);
    waitIdle(40);

    // ACT then PRE on bank0: tRAS spacing, head stalls in between
    base = cyc;
    applyStimulus(CMD_ACT, 14'h0200, 3'd0, 1'b1, 1);
    applyStimulus(CMD_PRE, 14'h0000, 3'd0, 1'b1, 9);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("pre_blocked_ren", 32'(bus.fifo_ren), 32'd0);
    end
    waitIdle(40);

    // Independent ACTs back to back, then WRs spaced by tCCD
    base = cyc;
    for (int i = 0; i < 4; i++) applyStimulus(CMD_ACT, 14'(16 * i), 3'(i), 1'b1, i + 1);
    waitIdle(40);
    base = cyc;
    for (int i = 0; i < 4; i++) applyStimulus(CMD_WR, 14'(64 + i), 3'(i), 1'b1, 2 * i + 1);
    waitIdle(40);

    // REF waits for trp[1], next ACT lands tRFC after REF
    base = cyc;
    applyStimulus(CMD_PRE, 14'h0000, 3'd1, 1'b1, 1);
    applyStimulus(CMD_REF, 14'h0000, 3'd0, 1'b1, 4);
    applyStimulus(CMD_ACT, 14'h0300, 3'd6, 1'b1, 24);
    waitIdle(60);

    // Unknown code is consumed silently
    applyStimulus(4'b1111, 14'h3fff, 3'd7, 1'b0, 0);
    #1;
    checkOutput("unk_ren", 32'(bus.fifo_ren), 32'd1);
    @(negedge clk);
    checkOutput("unk_cmd_issued", 32'(bus.cmd_issued), 32'd0);
    checkOutput("unk_consumed", 32'(fifo_mem.size()), 32'd0);

    // Disabled for 5 cycles with ACT at the head
    bus.dispatch_en = 1'b0;
    applyStimulus(CMD_ACT, 14'h0400, 3'd4, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("dis_ren", 32'(bus.fifo_ren), 32'd0);
      @(negedge clk);
    end
    checkOutput("dis_head_kept", 32'(fifo_mem.size()), 32'd1);
    bus.dispatch_en = 1'b1;
    base = cyc;
    expectIssue(CMD_ACT, 14'h0400, 3'd4, 1);
    waitIdle(40);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_cmd_dispatcher.md
# issue_cmd_dispatcher

Reader side of the issue FIFO. Pops `{command, addr, bank}` entries in order and enforces per-bank and global DRAM timing. It drives the registered DRAM command/address/bank pins and never reorders entries. It sits between the issue FIFO and the DRAM PHY pins, and pops at most one entry per cycle.

## Interface
- `T_RCD`, default 3: ACT to RD/WR on the same bank, in cycles. Minimum 1.
- `T_RP`, default 3: PRE to ACT on the same bank.
- `T_RAS`, default 8: ACT to PRE on the same bank.
- `T_CCD`, default 2: RD/WR to RD/WR on any bank.
- `T_RFC`, default 20: REF to any command.
- `CNT_W`, default 5: timer width. Every T_* must be at most 2^CNT_W.

- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `dispatch_en`, in, 1: when 0, no pop and pins hold NOP; timers keep counting.
- `fifo_data`, in, 21: FIFO head, `{cmd[20:17], addr[16:3], bank[2:0]}`. Valid combinationally while `fifo_empty`=0.
- `fifo_empty`, in, 1: FIFO empty.
- `fifo_ren`, out, 1: pop strobe. Combinational, at most 1 per cycle.
- `dram_cs_n`, `dram_ras_n`, `dram_cas_n`, `dram_we_n`, out, 1 each: command pins, registered.
- `dram_addr`, out, 14: registered.
- `dram_ba`, out, 3: registered.
- `cmd_issued`, out, 1: registered pulse, aligned with a non-NOP command on the pins.
- `timer_busy`, out, 1: registered; 1 if any timer is nonzero.

## Operation
- Command encoding is `{cs_n, ras_n, cas_n, we_n}`:
  - ACT=4'b0011, RD=4'b0101, WR=4'b0100, PRE=4'b0010, REF=4'b0001, NOP=4'b0111.
  - Any other code is treated as NOP.
- Timers, all saturating down-counters that decrement by 1 each cycle and stop at 0:
  - per bank: `trcd[b]`, `trp[b]`, `tras[b]`;
  - global: `tccd`, `trfc`.
- Head legality (head = `fifo_data`, b = its bank):
  - ACT: `trp[b]`==0 and `trfc`==0.
  - RD/WR: `trcd[b]`==0, `tccd`==0 and `trfc`==0.
  - PRE: `tras[b]`==0 and `trfc`==0.
  - REF: all eight `trp`==0 and `trfc`==0.
  - NOP/unknown: always legal.
- Pop rule: `fifo_ren` = `rst_n` & `dispatch_en` & !`fifo_empty` & legal(head).
- On a pop, at the clock edge:
  - the pins take the head's command, addr and bank;
  - the matching timer(s) load T-1: ACT loads `trcd[b]` and `tras[b]`; PRE loads `trp[b]`; RD/WR loads `tccd`; REF loads `trfc`.
  - A load overrides the decrement in that cycle.
- No pop: pins drive NOP. `dram_addr` and `dram_ba` hold their last values.
- A popped NOP/unknown entry is consumed, drives NOP on the pins and leaves `cmd_issued`=0.
- A blocked head stalls the queue. There is no bypass.
- State (derived, exposed for assertions):
  - IDLE: empty or disabled.
  - WAIT: head present but illegal.
  - ISSUE: `fifo_ren`=1.
  - Transitions follow the pop rule every cycle.

## Timing
- Reset values:
  - cs_n=0, ras_n/cas_n/we_n=1 (NOP);
  - `dram_addr`=0, `dram_ba`=0;
  - `cmd_issued`=0, `timer_busy`=0, all timers 0.
  - `fifo_ren`=0 while `rst_n`=0.
- Latency: a head that is legal in cycle N pops in N and appears on the pins in N+1.
- Minimum spacing of dependent commands on the pins is exactly T. Example: ACT on the pins at N+1 puts the earliest same-bank RD on the pins at N+1+T_RCD.
- Back-to-back independent commands issue every cycle.
- Reset asserted mid-stream:
  - timers clear and the pins return to NOP on the next edge;
  - no pop occurs in the reset cycle;
  - the FIFO head is not consumed.
- Empty and the FIFO pointer wrap are owned by the FIFO. The dispatcher only trusts `fifo_data` when `fifo_empty`=0.
- Dropping `dispatch_en` takes effect in the same cycle: no pop, NOP on the pins at the next edge.

## Structure
- Package `mc_cmd_pkg` holds:
  - the command encodings;
  - the `issue_fifo_cmd_in_t` struct (cmd 4 / addr 14 / bank 3);
  - `ISU_FIFO_WIDTH`=21.
  - The FIFO and the dispatcher share this package.
- Sub-module `bank_timer`: holds `trcd`/`trp`/`tras` for one bank with load/decrement and ready flags. It is instantiated 8 times.
- Global timers, legality mux and pin registers live in the top level.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with a non-empty FIFO (head ACT) → `fifo_ren`=0, pins 0111, `cmd_issued`=0.
- **ACT then RD:** ACT bank2 addr 0x0100, then RD bank2 addr 0x0010, defaults → ACT on the pins at cycle k, RD at k+3. Also RD on bank5 with no prior ACT on bank5 issues immediately.
- **ACT then PRE:** ACT bank0, then PRE bank0 → PRE on the pins exactly 8 cycles after ACT; `fifo_ren` low for the 7 intervening cycles.
- **Column spacing:** four WRs to banks 0-3, all activated long before → pins 4'b0100 every 2 cycles.
- **Refresh:** REF with PRE bank1 issued 1 cycle earlier → REF waits until `trp[1]`=0. After REF, the next ACT lands 20 cycles later.
- **Unknown code and disable:** unknown cmd 4'b1111 → popped in 1 cycle, pins NOP, `cmd_issued`=0. Then set `dispatch_en`=0 for 5 cycles with ACT at the head → no pop; the ACT issues 1 cycle after re-enable.
